// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier datapath.
// Provides the default data width, the output-register FSM state encoding
// and the source index codes used on the 3-bit select / op bus.
package mult_pkg;

    localparam int WIDTH = 16;

    typedef enum logic {
        VAZIO = 1'b0,
        CHEIO = 1'b1
    } estado_t;

    localparam logic [2:0] IDX_A = 3'd0;
    localparam logic [2:0] IDX_B = 3'd1;
    localparam logic [2:0] IDX_C = 3'd2;
    localparam logic [2:0] IDX_D = 3'd3;
    localparam logic [2:0] IDX_E = 3'd4;
    localparam logic [2:0] IDX_F = 3'd5;

endpackage

// File: rtl/mux_six_to_one.sv
// Six-input word selector.
// Ports:
//   sel        - source index, IDX_A..IDX_F
//   a..f       - source words
//   y          - selected word (zero for unused codes 6 and 7)
module mux_six_to_one
    import mult_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic [2:0]   sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    input  logic [W-1:0] e,
    input  logic [W-1:0] f,
    output logic [W-1:0] y
);

    always_comb begin
        y = '0;
        case (sel)
            IDX_A:   y = a;
            IDX_B:   y = b;
            IDX_C:   y = c;
            IDX_D:   y = d;
            IDX_E:   y = e;
            IDX_F:   y = f;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/arbitro_mux_seis.sv
// Round-robin arbiter plus holding register for six data sources.
// Picks one requester per free slot, captures its word and presents it
// downstream with a valid/ready handshake.
// Ports:
//   clock, reset      - rising-edge clock, async active-high reset
//   req[5:0]          - level requests, bit i = source i (a..f)
//   a..f              - source words
//   gnt[5:0]          - one-hot grant, combinational, capture cycle only
//   op[2:0]           - index of the held word
//   saida             - held word
//   saida_valida      - held word is valid
//   saida_pronta      - consumer takes the held word this cycle
//   ocupado           - same as saida_valida
//
// state | meaning
// ------+------------------------------------------
// VAZIO | holding register empty
// CHEIO | word held, waiting for saida_pronta
module arbitro_mux_seis
    import mult_pkg::*;
#(
    parameter int WIDTH = mult_pkg::WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       req,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    output logic [5:0]       gnt,
    output logic [2:0]       op,
    output logic [WIDTH-1:0] saida,
    output logic             saida_valida,
    input  logic             saida_pronta,
    output logic             ocupado
);

    // Returns {found, index}. Search starts one past the last winner and
    // wraps modulo 6, so the last winner has the lowest priority.
    function automatic logic [3:0] rr_pick(input logic [5:0] r, input logic [2:0] last);
        logic       found;
        logic [2:0] idx;
        logic [3:0] s;
        found = 1'b0;
        idx   = IDX_A;
        for (int i = 1; i <= 6; i++) begin
            s = {1'b0, last} + 4'(i);
            if (s >= 4'd6) begin
                s = s - 4'd6;
            end
            if (!found && r[s[2:0]]) begin
                found = 1'b1;
                idx   = s[2:0];
            end
        end
        return {found, idx};
    endfunction

    estado_t          state, next_state;
    logic [2:0]       ultimo;
    logic [3:0]       pick;
    logic [2:0]       vencedor;
    logic             slot_livre;
    logic             concede;
    logic [WIDTH-1:0] dado_sel;

    assign pick     = rr_pick(req, ultimo);
    assign vencedor = pick[2:0];

    mux_six_to_one #(.W(WIDTH)) u_mux (
        .sel (vencedor),
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d),
        .e   (e),
        .f   (f),
        .y   (dado_sel)
    );

    always_comb begin
        slot_livre = 1'b0;
        concede    = 1'b0;
        next_state = state;
        gnt        = 6'b000000;

        // A held word leaving this cycle frees the slot for a same-edge refill.
        slot_livre = (state == VAZIO) || saida_pronta;
        concede    = slot_livre && pick[3] && !reset;

        if (concede) begin
            gnt = 6'b000001 << vencedor;
        end

        case (state)
            VAZIO: next_state = concede ? CHEIO : VAZIO;
            CHEIO: begin
                if (slot_livre) begin
                    next_state = concede ? CHEIO : VAZIO;
                end else begin
                    next_state = CHEIO;
                end
            end
            default: next_state = VAZIO;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= VAZIO;
            ultimo <= IDX_F;
            saida  <= '0;
            op     <= IDX_A;
        end else begin
            state <= next_state;
            if (concede) begin
                saida  <= dado_sel;
                op     <= vencedor;
                ultimo <= vencedor;
            end
        end
    end

    assign saida_valida = (state == CHEIO);
    assign ocupado      = saida_valida;

endmodule

// File: tb/tb_arbitro_mux_seis.sv
module tb_arbitro_mux_seis;

    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset;
    logic [5:0]   req;
    logic [W-1:0] a, b, c, d, e, f;
    logic [5:0]   gnt;
    logic [2:0]   op;
    logic [W-1:0] saida;
    logic         saida_valida;
    logic         saida_pronta;
    logic         ocupado;

    int n_cmp = 0;
    int n_err = 0;

    arbitro_mux_seis #(.WIDTH(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .a            (a),
        .b            (b),
        .c            (c),
        .d            (d),
        .e            (e),
        .f            (f),
        .gnt          (gnt),
        .op           (op),
        .saida        (saida),
        .saida_valida (saida_valida),
        .saida_pronta (saida_pronta),
        .ocupado      (ocupado)
    );

    always #5 clock = ~clock;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = 6'b111111;
        saida_pronta = 1'b1;
        a = 16'd1; b = 16'd2; c = 16'd3; d = 16'd4; e = 16'd5; f = 16'd6;
        #2;
        n_cmp++;
        if (gnt !== 6'b000000) begin
            n_err++; $display("FAIL reset_gnt got %b want %b", gnt, 6'b000000);
        end
        n_cmp++;
        if ({saida_valida, ocupado, op, saida} !== {1'b0, 1'b0, 3'd0, 16'd0}) begin
            n_err++; $display("FAIL reset_outs got v=%b o=%b op=%0d s=%0d want all 0", saida_valida, ocupado, op, saida);
        end
        step();
        n_cmp++;
        if (saida_valida !== 1'b0) begin
            n_err++; $display("FAIL reset_hold_valid got %b want 0", saida_valida);
        end
        reset = 1'b0;
        req = 6'b000000;
        step();
    endtask

    task automatic test_single();
        req = 6'b000100;
        c = 16'd3;
        saida_pronta = 1'b1;
        #1;
        n_cmp++;
        if (gnt !== 6'b000100) begin
            n_err++; $display("FAIL single_gnt got %b want %b", gnt, 6'b000100);
        end
        step();
        n_cmp++;
        if ({saida, op, saida_valida, ocupado} !== {16'd3, 3'd2, 1'b1, 1'b1}) begin
            n_err++; $display("FAIL single_capture got s=%0d op=%0d v=%b o=%b want s=3 op=2 v=1 o=1", saida, op, saida_valida, ocupado);
        end
        req = 6'b000000;
        #1;
        n_cmp++;
        if (gnt !== 6'b000000) begin
            n_err++; $display("FAIL single_idle_gnt got %b want 0", gnt);
        end
        step();
        n_cmp++;
        if (saida_valida !== 1'b0) begin
            n_err++; $display("FAIL single_drain got %b want 0", saida_valida);
        end
    endtask

    task automatic test_rotation();
        logic [5:0]   exp_g;
        logic [2:0]   exp_op;
        logic [W-1:0] exp_s;
        pulse_reset();
        a = 16'd1; b = 16'd2; c = 16'd3; d = 16'd4; e = 16'd5; f = 16'd6;
        req = 6'b111111;
        saida_pronta = 1'b1;
        for (int k = 0; k < 7; k++) begin
            exp_op = 3'(k % 6);
            exp_g  = 6'b000001 << exp_op;
            exp_s  = W'(k % 6 + 1);
            #1;
            n_cmp++;
            if (gnt !== exp_g) begin
                n_err++; $display("FAIL rot_gnt[%0d] got %b want %b", k, gnt, exp_g);
            end
            step();
            n_cmp++;
            if ({op, saida, saida_valida} !== {exp_op, exp_s, 1'b1}) begin
                n_err++; $display("FAIL rot_out[%0d] got op=%0d s=%0d v=%b want op=%0d s=%0d v=1", k, op, saida, saida_valida, exp_op, exp_s);
            end
        end
        req = 6'b000000;
        step();
    endtask

    task automatic test_wrap();
        pulse_reset();
        saida_pronta = 1'b1;
        req = 6'b010000;
        step();
        n_cmp++;
        if (op !== 3'd4) begin
            n_err++; $display("FAIL wrap_setup got op=%0d want 4", op);
        end
        req = 6'b010001;
        #1;
        n_cmp++;
        if (gnt !== 6'b000001) begin
            n_err++; $display("FAIL wrap_gnt_a got %b want %b", gnt, 6'b000001);
        end
        step();
        n_cmp++;
        if ({op, saida} !== {3'd0, 16'd1}) begin
            n_err++; $display("FAIL wrap_out_a got op=%0d s=%0d want op=0 s=1", op, saida);
        end
        #1;
        n_cmp++;
        if (gnt !== 6'b010000) begin
            n_err++; $display("FAIL wrap_gnt_e got %b want %b", gnt, 6'b010000);
        end
        step();
        n_cmp++;
        if ({op, saida} !== {3'd4, 16'd5}) begin
            n_err++; $display("FAIL wrap_out_e got op=%0d s=%0d want op=4 s=5", op, saida);
        end
        req = 6'b000000;
        step();
    endtask

    task automatic test_backpressure();
        pulse_reset();
        a = 16'd10;
        b = 16'd20;
        saida_pronta = 1'b1;
        req = 6'b000001;
        step();
        req = 6'b000010;
        saida_pronta = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++;
            if (gnt !== 6'b000000) begin
                n_err++; $display("FAIL bp_gnt[%0d] got %b want 0", k, gnt);
            end
            n_cmp++;
            if ({saida, op, saida_valida} !== {16'd10, 3'd0, 1'b1}) begin
                n_err++; $display("FAIL bp_hold[%0d] got s=%0d op=%0d v=%b want s=10 op=0 v=1", k, saida, op, saida_valida);
            end
            step();
        end
        saida_pronta = 1'b1;
        #1;
        n_cmp++;
        if (gnt !== 6'b000010) begin
            n_err++; $display("FAIL bp_release_gnt got %b want %b", gnt, 6'b000010);
        end
        step();
        n_cmp++;
        if ({saida, op, saida_valida} !== {16'd20, 3'd1, 1'b1}) begin
            n_err++; $display("FAIL bp_release_out got s=%0d op=%0d v=%b want s=20 op=1 v=1", saida, op, saida_valida);
        end
    endtask

    task automatic test_accept_empty();
        req = 6'b000000;
        saida_pronta = 1'b1;
        #1;
        n_cmp++;
        if (gnt !== 6'b000000) begin
            n_err++; $display("FAIL acc_gnt got %b want 0", gnt);
        end
        step();
        n_cmp++;
        if ({saida_valida, ocupado, saida, op} !== {1'b0, 1'b0, 16'd20, 3'd1}) begin
            n_err++; $display("FAIL acc_empty got v=%b o=%b s=%0d op=%0d want v=0 o=0 s=20 op=1", saida_valida, ocupado, saida, op);
        end
    endtask

    task automatic test_midrun_reset();
        a = 16'd1;
        d = 16'd4;
        saida_pronta = 1'b0;
        req = 6'b001000;
        step();
        n_cmp++;
        if ({saida_valida, saida, op} !== {1'b1, 16'd4, 3'd3}) begin
            n_err++; $display("FAIL mid_setup got v=%b s=%0d op=%0d want v=1 s=4 op=3", saida_valida, saida, op);
        end
        req = 6'b111111;
        saida_pronta = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({saida_valida, ocupado, saida, op, gnt} !== {1'b0, 1'b0, 16'd0, 3'd0, 6'd0}) begin
            n_err++; $display("FAIL mid_reset got v=%b o=%b s=%0d op=%0d g=%b want all 0", saida_valida, ocupado, saida, op, gnt);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (gnt !== 6'b000001) begin
            n_err++; $display("FAIL mid_first_gnt got %b want %b", gnt, 6'b000001);
        end
        step();
        n_cmp++;
        if ({op, saida, saida_valida} !== {3'd0, 16'd1, 1'b1}) begin
            n_err++; $display("FAIL mid_first_out got op=%0d s=%0d v=%b want op=0 s=1 v=1", op, saida, saida_valida);
        end
    endtask

    initial begin
        reset = 1'b1;
        req = '0;
        saida_pronta = 1'b0;
        a = '0; b = '0; c = '0; d = '0; e = '0; f = '0;
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_backpressure();
        test_accept_empty();
        test_midrun_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
